// File: rtl/vga_vram_arbiter.sv
// Video RAM arbiter for the 32x32 16-colour display: fixed scanout fetch slots,
// CPU req/ack access in the remaining cycles, and palette lookup to 15-bit rgb.
module vga_vram_arbiter #(
  parameter int H_START = 64,
  parameter int CELL_H  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        display_on,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [9:0]  cpu_addr,
  input  logic [3:0]  cpu_wdata,
  output logic [3:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [9:0]  ram_addr,
  output logic        ram_we,
  output logic [3:0]  ram_wdata,
  input  logic [3:0]  ram_rdata,
  output logic [14:0] rgb
);

  localparam int SUB_W = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_H - 1);
  localparam logic [9:0] SLOT_FIRST = 10'(H_START - 2);
  localparam logic [9:0] SLOT_LAST  = 10'(H_START + 494);
  localparam logic [9:0] VIS_FIRST  = 10'(H_START);
  localparam logic [9:0] VIS_END    = 10'(H_START + 512);
  localparam logic [9:0] LINE_LAST  = 10'd639;
  localparam logic [9:0] V_ACTIVE   = 10'd480;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t           state, state_next;
  logic [SUB_W-1:0] subrow;
  logic [4:0]       row;
  logic [4:0]       slot_col;
  logic             in_frame, video_slot, grant;
  logic             slot_d, we_q;
  logic [9:0]       addr_q;
  logic [3:0]       wdata_q;
  logic [3:0]       color;

  function automatic logic [14:0] palette(input logic [3:0] idx);
    case (idx)
      4'd0:    palette = {5'd0,  5'd0,  5'd0};
      4'd1:    palette = {5'd31, 5'd31, 5'd31};
      4'd2:    palette = {5'd5,  5'd6,  5'd17};
      4'd3:    palette = {5'd25, 5'd24, 5'd13};
      4'd4:    palette = {5'd20, 5'd7,  5'd17};
      4'd5:    palette = {5'd8,  5'd21, 5'd11};
      4'd6:    palette = {5'd19, 5'd4,  5'd6};
      4'd7:    palette = {5'd14, 5'd25, 5'd23};
      4'd8:    palette = {5'd4,  5'd10, 5'd17};
      4'd9:    palette = {5'd0,  5'd7,  5'd10};
      4'd10:   palette = {5'd12, 5'd13, 5'd23};
      4'd11:   palette = {5'd9,  5'd9,  5'd9};
      4'd12:   palette = {5'd15, 5'd15, 5'd15};
      4'd13:   palette = {5'd17, 5'd31, 5'd19};
      4'd14:   palette = {5'd27, 5'd12, 5'd13};
      default: palette = {5'd21, 5'd21, 5'd21};
    endcase
  endfunction

  // Reset gates the slot and grant decodes so the RAM port goes quiet at once.
  assign in_frame   = (vpos < V_ACTIVE);
  assign video_slot = !reset && in_frame && (hpos[3:0] == 4'd14) &&
                      (hpos >= SLOT_FIRST) && (hpos <= SLOT_LAST);
  assign slot_col   = 5'((hpos - SLOT_FIRST) >> 4);
  assign grant      = !reset && (state == S_IDLE) && cpu_req && !video_slot;

  assign ram_addr  = video_slot ? {row, slot_col} : (grant ? cpu_addr : addr_q);
  assign ram_we    = grant && cpu_we;
  assign ram_wdata = grant ? cpu_wdata : wdata_q;

  always_comb begin
    state_next = state;
    cpu_ack    = 1'b0;
    case (state)
      S_IDLE: if (grant) state_next = S_WAIT;
      S_WAIT: state_next = S_ACK;
      S_ACK: begin
        cpu_ack    = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      cpu_rdata <= 4'd0;
      addr_q    <= 10'd0;
      wdata_q   <= 4'd0;
    end else begin
      state   <= state_next;
      addr_q  <= ram_addr;
      wdata_q <= ram_wdata;
      if (grant) we_q <= cpu_we;
      if (state == S_WAIT && !we_q) cpu_rdata <= ram_rdata;
    end
  end

  // Fetch data returns one cycle after the slot; latch it on the following edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_d <= 1'b0;
      color  <= 4'd0;
    end else begin
      slot_d <= video_slot;
      if (slot_d) color <= ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      subrow <= '0;
      row    <= 5'd0;
    end else if (!in_frame) begin
      subrow <= '0;
      row    <= 5'd0;
    end else if (hpos == LINE_LAST) begin
      if (subrow == SUB_LAST) begin
        subrow <= '0;
        row    <= row + 5'd1;
      end else begin
        subrow <= subrow + 1'b1;
      end
    end
  end

  assign rgb = (display_on && in_frame && hpos >= VIS_FIRST && hpos < VIS_END) ?
               palette(color) : 15'd0;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed self-checking bench for vga_vram_arbiter with a behavioural
// registered-read video RAM and hand-driven hpos/vpos positions.
module tb_vga_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos, vpos;
  logic        display_on;
  logic        cpu_req, cpu_we;
  logic [9:0]  cpu_addr;
  logic [3:0]  cpu_wdata;
  logic [3:0]  cpu_rdata;
  logic        cpu_ack;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_wdata;
  logic [3:0]  ram_rdata;
  logic [14:0] rgb;

  int checks = 0;
  int errors = 0;

  logic [3:0] mem [1024];

  localparam logic [14:0] PAL [16] = '{
    15'h0000, 15'h7FFF, 15'h14D1, 15'h670D,
    15'h50F1, 15'h22AB, 15'h4C86, 15'h3B37,
    15'h1151, 15'h00EA, 15'h31B7, 15'h2529,
    15'h3DEF, 15'h47F3, 15'h6D8D, 15'h56B5
  };

  vga_vram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .rgb        (rgb)
  );

  always #5 clk = ~clk;

  // Synchronous video RAM with one-cycle registered read
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired got timeout want finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pos(input int h, input int v);
    hpos       = 10'(h);
    vpos       = 10'(v);
    display_on = (h < 640) && (v < 480);
  endtask

  function automatic logic [14:0] expect_pixel(input int mode, input int v, input int h);
    if (v >= 480 || h < 64 || h >= 576) return 15'd0;
    if (mode == 0) return (v >= 15 && v <= 29 && h >= 80 && h <= 95) ? PAL[2] : 15'd0;
    return PAL[((h - 64) >> 4) & 15];
  endfunction

  // Single CPU transaction with position held; ack_at is the cycle offset of cpu_ack
  task automatic cpu_access(input logic we, input logic [9:0] addr, input logic [3:0] wd,
                            output logic [3:0] rd, output int ack_at);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    ack_at = -1; rd = 4'd0;
    for (int i = 0; i < 8 && ack_at < 0; i++) begin
      #1;
      if (cpu_ack === 1'b1) begin
        ack_at = i;
        rd = cpu_rdata;
      end
      tick();
    end
    cpu_req = 1'b0;
  endtask

  task automatic scan_line(input int v, input int h0, input int h1, input int mode);
    logic [14:0] exp_rgb;
    logic [9:0]  exp_addr;
    for (int h = h0; h <= h1; h++) begin
      set_pos(h, v);
      #1;
      exp_rgb = expect_pixel(mode, v, h);
      checks++;
      if (rgb !== exp_rgb) begin
        errors++;
        $display("[TB] FAIL scan_rgb v=%0d h=%0d got %h want %h", v, h, rgb, exp_rgb);
      end
      if ((h % 16) == 14 && h >= 62 && h <= 558) begin
        exp_addr = {5'(v / 15), 5'((h - 62) / 16)};
        checks++;
        if (ram_addr !== exp_addr || ram_we !== 1'b0) begin
          errors++;
          $display("[TB] FAIL slot_addr v=%0d h=%0d got %h/%b want %h/0", v, h, ram_addr, ram_we, exp_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [3:0] rd;
    int ack_at;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'd0; cpu_wdata = 4'd0;
    set_pos(0, 500);
    tick(); tick();
    #1;
    checks++;
    if (rgb !== 15'd0 || cpu_ack !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 10'd0 ||
        cpu_rdata !== 4'd0 || ram_wdata !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_values got rgb=%h ack=%b we=%b addr=%h rd=%h wd=%h want all 0",
               rgb, cpu_ack, ram_we, ram_addr, cpu_rdata, ram_wdata);
    end
    reset = 1'b0;
    tick();
    cpu_access(1'b1, 10'd0, 4'd9, rd, ack_at);
    checks++;
    if (ack_at !== 2) begin errors++; $display("[TB] FAIL reset_setup_ack got %0d want 2", ack_at); end
    tick();
    for (int h = 60; h < 70; h++) begin
      set_pos(h, 0);
      #1;
      if (h >= 64) begin
        checks++;
        if (rgb !== PAL[9]) begin errors++; $display("[TB] FAIL pre_reset_rgb h=%0d got %h want %h", h, rgb, PAL[9]); end
      end
      tick();
    end
    set_pos(70, 0);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd3; cpu_wdata = 4'd5;
    reset = 1'b1;
    #1;
    checks++;
    if (rgb !== 15'd0 || cpu_ack !== 1'b0 || ram_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midline_reset got rgb=%h ack=%b we=%b want 0/0/0", rgb, cpu_ack, ram_we);
    end
    tick();
    reset = 1'b0; cpu_req = 1'b0;
    for (int h = 60; h <= 80; h++) begin
      set_pos(h, 1);
      #1;
      if (h == 62 || h == 78) begin
        checks++;
        if (ram_addr !== ((h == 62) ? 10'd0 : 10'd1)) begin
          errors++; $display("[TB] FAIL post_reset_fetch h=%0d got %h want %h", h, ram_addr, (h == 62) ? 10'd0 : 10'd1);
        end
      end
      if (h >= 64) begin
        checks++;
        if (rgb !== ((h < 80) ? PAL[9] : PAL[0])) begin
          errors++; $display("[TB] FAIL post_reset_rgb h=%0d got %h want %h", h, rgb, (h < 80) ? PAL[9] : PAL[0]);
        end
      end
      tick();
    end
    set_pos(0, 500);
    cpu_access(1'b1, 10'd0, 4'd0, rd, ack_at);
  endtask

  task automatic test_write_scan();
    set_pos(0, 500);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h021; cpu_wdata = 4'd2;
    #1;
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 10'h021 || ram_wdata !== 4'd2) begin
      errors++; $display("[TB] FAIL write_grant got we=%b addr=%h wd=%h want 1/021/2", ram_we, ram_addr, ram_wdata);
    end
    tick(); #1;
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL write_ack_g1 got %b want 0", cpu_ack); end
    tick(); #1;
    checks++;
    if (cpu_ack !== 1'b1) begin errors++; $display("[TB] FAIL write_ack_g2 got %b want 1", cpu_ack); end
    tick();
    cpu_req = 1'b0;
    #1;
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL write_ack_len got %b want 0", cpu_ack); end
    tick();
    for (int v = 0; v <= 30; v++) begin
      if (v == 14 || v == 15 || v == 29 || v == 30) scan_line(v, 60, 639, 0);
      else begin set_pos(639, v); tick(); end
    end
    set_pos(0, 500);
    tick();
  endtask

  task automatic test_slot_conflict();
    logic [3:0] rd;
    int ack_at;
    set_pos(0, 500);
    cpu_access(1'b1, 10'd5, 4'd12, rd, ack_at);
    checks++;
    if (ack_at !== 2) begin errors++; $display("[TB] FAIL conflict_setup_ack got %0d want 2", ack_at); end
    cpu_access(1'b1, 10'd0, 4'd9, rd, ack_at);
    tick();
    set_pos(60, 0); tick();
    set_pos(61, 0); tick();
    set_pos(62, 0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
    #1;
    checks++;
    if (ram_addr !== 10'd0 || ram_we !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++; $display("[TB] FAIL slot_wins got addr=%h we=%b ack=%b want 000/0/0", ram_addr, ram_we, cpu_ack);
    end
    tick();
    set_pos(63, 0); #1;
    checks++;
    if (ram_addr !== 10'd5) begin errors++; $display("[TB] FAIL grant_after_slot got %h want 005", ram_addr); end
    tick();
    set_pos(64, 0); #1;
    checks++;
    if (cpu_ack !== 1'b0 || rgb !== PAL[9]) begin
      errors++; $display("[TB] FAIL conflict_wait got ack=%b rgb=%h want 0/%h", cpu_ack, rgb, PAL[9]);
    end
    tick();
    set_pos(65, 0); #1;
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 4'd12) begin
      errors++; $display("[TB] FAIL conflict_ack got ack=%b rdata=%h want 1/c", cpu_ack, cpu_rdata);
    end
    tick();
    cpu_req = 1'b0;
    for (int h = 66; h <= 80; h++) begin
      set_pos(h, 0);
      #1;
      checks++;
      if (rgb !== ((h < 80) ? PAL[9] : PAL[0]) || cpu_ack !== 1'b0) begin
        errors++; $display("[TB] FAIL conflict_video h=%0d got rgb=%h ack=%b want %h/0", h, rgb, cpu_ack, (h < 80) ? PAL[9] : PAL[0]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int g1, g2, n_we, n_ack, ack_at;
    logic prev_ack;
    logic [3:0] rd;
    g1 = -1; g2 = -1; n_we = 0; n_ack = 0; prev_ack = 1'b0;
    set_pos(0, 500);
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h100; cpu_wdata = 4'd3; end
      if (i == 3) begin cpu_addr = 10'h101; cpu_wdata = 4'd4; end
      if (i == 6) cpu_req = 1'b0;
      #1;
      if (ram_we === 1'b1) begin
        n_we++;
        if (g1 < 0) g1 = i; else if (g2 < 0) g2 = i;
      end
      if (cpu_ack === 1'b1) n_ack++;
      checks++;
      if (cpu_ack === 1'b1 && prev_ack === 1'b1) begin
        errors++; $display("[TB] FAIL ack_width cycle=%0d got 2 cycles want 1", i);
      end
      prev_ack = cpu_ack;
      tick();
    end
    checks++;
    if (g1 !== 0 || g2 !== 3 || n_we !== 2 || n_ack !== 2) begin
      errors++; $display("[TB] FAIL back_to_back got g1=%0d g2=%0d we=%0d acks=%0d want 0/3/2/2", g1, g2, n_we, n_ack);
    end
    cpu_access(1'b0, 10'h100, 4'd0, rd, ack_at);
    checks++;
    if (rd !== 4'd3 || ack_at !== 2) begin errors++; $display("[TB] FAIL b2b_read0 got %h@%0d want 3@2", rd, ack_at); end
    cpu_access(1'b0, 10'h101, 4'd0, rd, ack_at);
    checks++;
    if (rd !== 4'd4 || ack_at !== 2) begin errors++; $display("[TB] FAIL b2b_read1 got %h@%0d want 4@2", rd, ack_at); end
  endtask

  task automatic test_reset_wait();
    logic [3:0] rd;
    int ack_at;
    set_pos(0, 500);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h200; cpu_wdata = 4'd7;
    #1;
    checks++;
    if (ram_we !== 1'b1) begin errors++; $display("[TB] FAIL rw_grant got %b want 1", ram_we); end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (cpu_ack !== 1'b0 || ram_we !== 1'b0) begin
      errors++; $display("[TB] FAIL rw_in_reset got ack=%b we=%b want 0/0", cpu_ack, ram_we);
    end
    tick();
    reset = 1'b0; cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (cpu_ack !== 1'b0) begin errors++; $display("[TB] FAIL rw_no_ack cycle=%0d got 1 want 0", i); end
      tick();
    end
    cpu_access(1'b0, 10'h200, 4'd0, rd, ack_at);
    checks++;
    if (ack_at !== 2 || rd !== 4'd7) begin
      errors++; $display("[TB] FAIL rw_after got %h@%0d want 7@2", rd, ack_at);
    end
  endtask

  task automatic test_full_frame();
    logic [3:0] rd;
    int ack_at;
    set_pos(0, 500);
    for (int a = 0; a < 1024; a++) begin
      cpu_access(1'b1, 10'(a), 4'(a), rd, ack_at);
      checks++;
      if (ack_at !== 2) begin errors++; $display("[TB] FAIL fill_ack addr=%0d got %0d want 2", a, ack_at); end
    end
    tick();
    for (int v = 0; v < 480; v++) begin
      if (v == 0 || v == 14 || v == 15 || v == 479) scan_line(v, 60, 639, 1);
      else begin set_pos(639, v); tick(); end
    end
    for (int h = 64; h <= 80; h++) begin
      hpos = 10'(h); vpos = 10'd480; display_on = 1'b1;
      #1;
      checks++;
      if (rgb !== 15'd0) begin errors++; $display("[TB] FAIL vblank_rgb h=%0d got %h want 0", h, rgb); end
      tick();
    end
    hpos = 10'd100; vpos = 10'd10; display_on = 1'b0;
    #1;
    checks++;
    if (rgb !== 15'd0) begin errors++; $display("[TB] FAIL display_off got %h want 0", rgb); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 4'd0;
    ram_rdata = 4'd0;
    test_reset();
    test_write_scan();
    test_slot_conflict();
    test_back_to_back();
    test_reset_wait();
    test_full_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
